// File: rtl/e203_clk_ctrl_gen.sv
// e203_clk_ctrl_gen: per-channel clock gating with idle hysteresis, WFI masking and debug/scan overrides
module e203_clkgate (
  input  logic clk_in,
  input  logic test_mode,
  input  logic clock_en,
  output logic clk_out
);
  logic r_en;
  // Enable is captured while the clock is low so the gated clock never glitches
  always_latch if (!clk_in) r_en <= clock_en | test_mode;
  assign clk_out = clk_in & r_en;
endmodule

module e203_clk_ctrl_gen #(
  parameter int NCH = 6,
  parameter int HYST_W = 4,
  parameter logic [NCH-1:0] WFI_MASK = NCH'(1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              test_mode,
  input  logic              core_cgstop,
  input  logic              core_wfi,
  input  logic [NCH-1:0]    chan_active,
  input  logic [HYST_W-1:0] hyst_cfg,
  output logic              clk_aon,
  output logic [NCH-1:0]    clk_chan,
  output logic [NCH-1:0]    chan_en,
  output logic [NCH-1:0]    chan_ls,
  output logic              all_idle
);
  typedef enum logic [1:0] {RUN, HOLD, GATED} state_t;
  logic [NCH-1:0] w_act;
  logic [NCH-1:0] w_idle;
  assign w_act = chan_active & ~(WFI_MASK & {NCH{core_wfi}});
  assign clk_aon = clk;
  assign chan_ls = ~chan_en;
  assign all_idle = (&w_idle) & ~(|chan_en);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t r_state, w_nstate;
    logic [HYST_W-1:0] r_cnt, w_ncnt;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= GATED;
        r_cnt <= '0;
      end else begin
        r_state <= w_nstate;
        r_cnt <= w_ncnt;
      end
    end
    // hyst_cfg is only loaded on RUN->HOLD, so later changes leave the count alone
    always_comb begin
      w_nstate = r_state;
      w_ncnt = r_cnt;
      case (r_state)
        RUN: begin
          if (!w_act[i]) begin
            w_nstate = (hyst_cfg == '0) ? GATED : HOLD;
            w_ncnt = hyst_cfg;
          end
        end
        HOLD: begin
          if (w_act[i]) w_nstate = RUN;
          else begin
            w_nstate = (r_cnt == HYST_W'(1)) ? GATED : HOLD;
            w_ncnt = r_cnt - HYST_W'(1);
          end
        end
        default: w_nstate = w_act[i] ? RUN : GATED;
      endcase
    end
    assign w_idle[i] = r_state == GATED;
    assign chan_en[i] = core_cgstop | w_act[i] | (r_state != GATED);
    e203_clkgate u_cg (
      .clk_in   (clk),
      .test_mode(test_mode),
      .clock_en (chan_en[i]),
      .clk_out  (clk_chan[i])
    );
  end
endmodule

// File: tb/tb_e203_clk_ctrl_gen.sv
// tb_e203_clk_ctrl_gen: directed checks of hysteresis, WFI masking, overrides, reset and gating
module tb_e203_clk_ctrl_gen;
  logic clk = 1'b0;
  logic rst_n, test_mode, core_cgstop, core_wfi;
  logic [5:0] chan_active;
  logic [3:0] hyst_cfg;
  logic clk_aon, all_idle;
  logic [5:0] clk_chan, chan_en, chan_ls;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  e203_clk_ctrl_gen dut (
    .clk(clk), .rst_n(rst_n), .test_mode(test_mode), .core_cgstop(core_cgstop),
    .core_wfi(core_wfi), .chan_active(chan_active), .hyst_cfg(hyst_cfg),
    .clk_aon(clk_aon), .clk_chan(clk_chan), .chan_en(chan_en), .chan_ls(chan_ls),
    .all_idle(all_idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; test_mode = 1'b0; core_cgstop = 1'b0; core_wfi = 1'b0;
    chan_active = '0; hyst_cfg = '0;
    step(); step();
    chk("rst_en", 32'(chan_en), 32'h00);
    chk("rst_ls", 32'(chan_ls), 32'h3F);
    chk("rst_idle", 32'(all_idle), 32'd1);
    chan_active = 6'h04; #1;
    chk("rst_en_act", 32'(chan_en), 32'h04);
    chk("rst_idle_act", 32'(all_idle), 32'd0);
    chan_active = '0;
    rst_n = 1'b1;
    step();
    // hysteresis of 3 on channel 1
    hyst_cfg = 4'd3; chan_active = 6'h02; #1;
    chk("wake0", 32'(chan_en), 32'h02);
    step();
    chan_active = '0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) step();
      #1;
      chk($sformatf("hyst3_en_t%0d", k), 32'(chan_en[1]), 32'(k < 4));
    end
    chk("hyst3_ls", 32'(chan_ls[1]), 32'd1);
    chk("hyst3_idle", 32'(all_idle), 32'd1);
    // zero hysteresis pulse on channel 2
    hyst_cfg = 4'd0; chan_active = 6'h04; #1;
    chk("h0_t", 32'(chan_en[2]), 32'd1);
    step();
    chan_active = '0; #1;
    chk("h0_t1", 32'(chan_en[2]), 32'd1);
    step(); #1;
    chk("h0_t2", 32'(chan_en[2]), 32'd0);
    // WFI masks channel 0 only
    hyst_cfg = 4'd2; chan_active = 6'h3F;
    step(); step();
    core_wfi = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) step();
      #1;
      chk($sformatf("wfi_en_t%0d", k), 32'(chan_en), (k < 3) ? 32'h3F : 32'h3E);
    end
    core_wfi = 1'b0; chan_active = '0; hyst_cfg = 4'd0;
    step(); #1;
    chk("allgated_en", 32'(chan_en), 32'h00);
    chk("allgated_idle", 32'(all_idle), 32'd1);
    // cgstop overrides outputs while FSMs keep advancing
    core_cgstop = 1'b1; #1;
    chk("cg_en", 32'(chan_en), 32'h3F);
    chk("cg_ls", 32'(chan_ls), 32'h00);
    chk("cg_idle", 32'(all_idle), 32'd0);
    hyst_cfg = 4'd2; chan_active = 6'h08;
    step();
    chan_active = '0;
    step(); step();
    core_cgstop = 1'b0; #1;
    chk("cg_fsm_hold", 32'(chan_en), 32'h08);
    step(); #1;
    chk("cg_fsm_gated", 32'(chan_en), 32'h00);
    chk("cg_idle_back", 32'(all_idle), 32'd1);
    // hyst_cfg change during HOLD is ignored
    chan_active = 6'h02;
    step();
    chan_active = '0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) step();
      if (k == 1) hyst_cfg = 4'd9;
      #1;
      chk($sformatf("hchg_en_t%0d", k), 32'(chan_en[1]), 32'(k < 3));
    end
    // reset in the middle of a long HOLD
    hyst_cfg = 4'd15; chan_active = 6'h02;
    step();
    chan_active = '0;
    for (int k = 1; k <= 5; k++) step();
    #1;
    chk("rsthold_t5", 32'(chan_en[1]), 32'd1);
    rst_n = 1'b0; chan_active = 6'h10;
    step(); #1;
    chk("rsthold_t6", 32'(chan_en), 32'h10);
    rst_n = 1'b1; chan_active = '0; #1;
    chk("rsthold_gated", 32'(chan_en), 32'h00);
    chk("rsthold_idle", 32'(all_idle), 32'd1);
    // wake during the second HOLD cycle returns to RUN
    hyst_cfg = 4'd4; chan_active = 6'h20;
    step();
    chan_active = '0;
    step(); step();
    chan_active = 6'h20; #1;
    chk("wake_hold", 32'(chan_en[5]), 32'd1);
    step();
    chan_active = '0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      #1;
      chk($sformatf("rehyst_t%0d", k), 32'(chan_en[5]), 32'(k < 5));
    end
    // independent channels with staggered idles
    hyst_cfg = 4'd1; chan_active = 6'h03;
    step();
    chan_active = 6'h01; #1;
    chk("ind_t0", 32'(chan_en), 32'h03);
    step();
    chan_active = '0; #1;
    chk("ind_t1", 32'(chan_en), 32'h03);
    step(); #1;
    chk("ind_t2", 32'(chan_en), 32'h01);
    step(); #1;
    chk("ind_t3", 32'(chan_en), 32'h00);
    // test_mode opens every gate without touching enables
    test_mode = 1'b1; #1;
    chk("tm_en", 32'(chan_en), 32'h00);
    chk("tm_idle", 32'(all_idle), 32'd1);
    step();
    chk("tm_clk", 32'(clk_chan), 32'h3F);
    chk("tm_aon", 32'(clk_aon), 32'd1);
    test_mode = 1'b0;
    step();
    chk("gated_clk", 32'(clk_chan), 32'h00);
    chan_active = 6'h01;
    step();
    chk("en_clk", 32'(clk_chan), 32'h01);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/e203_clk_ctrl_gen.md
E203_CLK_CTRL_GEN -- requirements
Module: e203_clk_ctrl_gen

Interface
REQ-001 SHALL have parameter NCH, default 6, giving the number of gated clock channels (1..32).
REQ-002 SHALL have parameter HYST_W, default 4, giving the width of the idle-hysteresis count.
REQ-003 SHALL have parameter WFI_MASK, NCH bits, default 6'b000001; bit i=1 means channel i is suppressed by core_wfi.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is clocked on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset; reset is synchronous and active-low.
REQ-006 SHALL have port test_mode, input, 1, which forces every gated clock on for scan.
REQ-007 SHALL have port core_cgstop, input, 1, the CSR debug override that forces every channel enable to 1.
REQ-008 SHALL have port core_wfi, input, 1, the core wait-for-interrupt indication.
REQ-009 SHALL have port chan_active, input, NCH, the per-channel activity request.
REQ-010 SHALL have port hyst_cfg, input, HYST_W, the number of extra idle cycles to keep a channel clock on.
REQ-011 SHALL have port clk_aon, output, 1, driven as clk ungated.
REQ-012 SHALL have port clk_chan, output, NCH, the per-channel gated clock, one e203_clkgate instance per channel.
REQ-013 SHALL have port chan_en, output, NCH, the per-channel clock enable driving each gate.
REQ-014 SHALL have port chan_ls, output, NCH, the per-channel light-sleep indication, equal to ~chan_en.
REQ-015 SHALL have port all_idle, output, 1, asserted when every channel is in GATED and chan_en is all-zero.

Function
REQ-016 SHALL compute act_eff[i] = chan_active[i] & ~(WFI_MASK[i] & core_wfi), combinationally.
REQ-017 SHALL keep, per channel, a state in {RUN, HOLD, GATED} and a HYST_W-bit down-counter cnt.
REQ-018 In RUN: SHALL stay in RUN if act_eff=1; if act_eff=0 and hyst_cfg=0, SHALL move to GATED; otherwise SHALL move to HOLD and load cnt=hyst_cfg.
REQ-019 In HOLD: SHALL move to RUN if act_eff=1; otherwise, when cnt=1, SHALL move to GATED; otherwise SHALL decrement cnt.
REQ-020 In GATED: SHALL move to RUN if act_eff=1; otherwise SHALL stay in GATED.
REQ-021 SHALL drive chan_en[i] = core_cgstop | act_eff[i] | (state[i] != GATED), combinationally, so wake has zero latency.
REQ-022 For a given hyst_cfg=N, after the first idle cycle t in RUN, chan_en SHALL remain 1 through cycle t+N and SHALL be 0 from t+N+1, provided there is no new activity and core_cgstop=0.
REQ-023 SHALL sample hyst_cfg only on the RUN->HOLD transition; a change of hyst_cfg during HOLD SHALL NOT affect the running count.
REQ-024 core_cgstop SHALL override only chan_en, chan_ls and all_idle; the FSMs SHALL continue to advance normally.
REQ-025 test_mode SHALL force clk_chan to follow clk through e203_clkgate, and SHALL NOT alter chan_en, chan_ls, the FSMs or all_idle.
REQ-026 Channels SHALL be fully independent; simultaneous events on different channels SHALL NOT interact.
REQ-027 core_wfi rising with chan_active held high on a masked channel SHALL start that channel's hysteresis exactly as if chan_active had fallen.

Reset
REQ-028 While rst_n=0 at a clk edge, every channel SHALL go to GATED with cnt=0, including when reset arrives mid-HOLD.
REQ-029 During and after reset, chan_en SHALL equal core_cgstop | act_eff, and chan_ls its inverse.
REQ-030 all_idle SHALL be 1 after reset when chan_active=0 and core_cgstop=0.

Verification
REQ-031 Test hysteresis: hyst_cfg=3, chan_active[1] 1->0 at cycle t -> chan_en[1]=1 through t+3, =0 from t+4, chan_ls[1]=1 from t+4.
REQ-032 Test zero hysteresis: hyst_cfg=0, pulse chan_active[2] for 1 cycle at t -> chan_en[2]=1 at t and t+1, =0 at t+2.
REQ-033 Test WFI masking: chan_active=6'h3F held, core_wfi 0->1 at t, hyst_cfg=2 -> chan_en[0]=0 from t+3; chan_en[5:1] stay 1.
REQ-034 Test cgstop override: core_cgstop=1 with all channels GATED -> chan_en=6'h3F and all_idle=0 in the same cycle; after core_cgstop=0, chan_en returns to 0 with no FSM change.
REQ-035 Test reset mid-HOLD: hyst_cfg=15, rst_n=0 at t+5 of HOLD -> state GATED at t+6 and chan_en=act_eff.
REQ-036 Test wake during HOLD: hyst_cfg=4, re-assert activity in the 2nd HOLD cycle -> chan_en never drops and the channel returns to RUN next cycle.
